// File: rtl/tvc_pkg.sv
// rtl/tvc_pkg.sv - shared Triangles-vs-Circles constants and entry state type
package tvc_pkg;

    localparam int BOARD_SIZE = 10;
    localparam int COORD_W    = 4;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } entry_state_t;

endpackage

// File: rtl/move_entry_if.sv
// rtl/move_entry_if.sv - move entry to game controller signal bundle
interface move_entry_if #(
    parameter int COORD_W = tvc_pkg::COORD_W
);

    logic                   enable;
    logic                   activity_d;
    logic                   move_valid;
    logic                   entry_error;
    logic [COORD_W-1:0]     x_output;
    logic [COORD_W-1:0]     y_output;
    logic [2*COORD_W-1:0]   entry_bits;
    logic [3:0]             bit_count;

    modport master (
        input  enable,
        output activity_d, move_valid, entry_error,
        output x_output, y_output, entry_bits, bit_count
    );

    modport slave (
        output enable,
        input  activity_d, move_valid, entry_error,
        input  x_output, y_output, entry_bits, bit_count
    );

endinterface

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchronizer, debounce and press pulse for one button
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES);

    logic          s1;
    logic          s2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            count   <= '0;
            press   <= 1'b0;
        end else begin
            s1      <= button;
            s2      <= s1;
            level_d <= level;
            press   <= level & ~level_d;
            // Counter restarts on any agreement, so only an unbroken run flips the level.
            if (s2 == level) begin
                count <= '0;
            end else if (count == LAST) begin
                level <= s2;
                count <= '0;
            end else if (count != LIMIT) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/move_entry.sv
// rtl/move_entry.sv - button conditioning and 8-bit coordinate entry for the game FSM
module move_entry #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int COORD_W         = tvc_pkg::COORD_W,
    parameter int BOARD_SIZE      = tvc_pkg::BOARD_SIZE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             logic_0_button,
    input  logic             logic_1_button,
    input  logic             activity_button,
    move_entry_if.master     bus
);

    import tvc_pkg::*;

    localparam logic [3:0] FULL_COUNT = 4'(2 * COORD_W);

    logic press_0;
    logic press_1;
    logic press_act;
    logic x_ok;
    logic y_ok;
    entry_state_t state;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_0 (
        .clk(clk), .reset(reset), .button(logic_0_button), .press(press_0)
    );
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_1 (
        .clk(clk), .reset(reset), .button(logic_1_button), .press(press_1)
    );
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_act (
        .clk(clk), .reset(reset), .button(activity_button), .press(press_act)
    );

    assign x_ok = int'(bus.entry_bits[2*COORD_W-1 -: COORD_W]) < BOARD_SIZE;
    assign y_ok = int'(bus.entry_bits[COORD_W-1:0]) < BOARD_SIZE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= COLLECT;
            bus.entry_bits  <= '0;
            bus.bit_count   <= '0;
            bus.activity_d  <= 1'b0;
            bus.move_valid  <= 1'b0;
            bus.entry_error <= 1'b0;
            bus.x_output    <= '0;
            bus.y_output    <= '0;
        end else begin
            bus.activity_d  <= press_act;
            bus.move_valid  <= 1'b0;
            bus.entry_error <= 1'b0;
            if (!bus.enable) begin
                state          <= COLLECT;
                bus.entry_bits <= '0;
                bus.bit_count  <= '0;
            end else if (press_act) begin
                // Activity wins over a coincident data press; the bit is dropped.
                if (state == FULL && x_ok && y_ok) begin
                    bus.x_output   <= bus.entry_bits[2*COORD_W-1 -: COORD_W];
                    bus.y_output   <= bus.entry_bits[COORD_W-1:0];
                    bus.move_valid <= 1'b1;
                end else begin
                    bus.entry_error <= 1'b1;
                end
                state          <= COLLECT;
                bus.entry_bits <= '0;
                bus.bit_count  <= '0;
            end else if ((press_0 ^ press_1) && state == COLLECT) begin
                bus.entry_bits <= {bus.entry_bits[2*COORD_W-2:0], press_1};
                bus.bit_count  <= bus.bit_count + 4'd1;
                if (bus.bit_count == FULL_COUNT - 4'd1) begin
                    state <= FULL;
                end
            end
        end
    end

endmodule
